chan_mux_scan: RTL and testbench
================================

CHAN_MUX_SCAN -- requirements
Module: chan_mux_scan

Parameters
REQ-001 W, default 2: data width per channel, W >= 1.
REQ-002 N, default 4: channel count, N >= 2.
REQ-003 DWELL, default 4: cycles spent on each channel in scan mode, DWELL >= 1.

Interface
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  1  channel select mode: 0 = manual (channel from addr), 1 = scan (auto-rotate).
REQ-007 addr  input  CW=max(1,clog2(N))  manual channel select.
REQ-008 in_bus  input  N*W  channel data; channel k occupies bits [k*W +: W].
REQ-009 in_valid  input  N  per-channel data-valid.
REQ-010 out_ready  input  1  downstream accepts Mout this cycle.
REQ-011 Mout  output  W  registered selected data.
REQ-012 out_valid  output  1  Mout holds an unconsumed sample.
REQ-013 out_ch  output  CW  channel index Mout came from.
REQ-014 cur_ch  output  CW  channel currently selected.

Function
REQ-015 FSM has states MANUAL and SCAN; state follows mode, sampled every cycle.
REQ-016 MANUAL: cur_ch <= addr every cycle; dwell counter held at 0.
REQ-017 SCAN: dwell counter increments each cycle; at DWELL-1 it clears and cur_ch advances by 1.
REQ-018 SCAN wrap: after channel N-1, cur_ch returns to 0.
REQ-019 Mode change MANUAL->SCAN: scan starts at addr sampled that cycle, counter cleared.
REQ-020 Mode change SCAN->MANUAL: counter cleared, cur_ch <= addr.
REQ-021 Output slot is free when out_valid=0 or out_ready=1.
REQ-022 Capture: if the slot is free, cur_ch < N, and in_valid[cur_ch]=1, then Mout <= channel cur_ch data, out_ch <= cur_ch, and out_valid <= 1.
REQ-023 If no capture occurs and out_ready=1, out_valid <= 0; Mout and out_ch hold.
REQ-024 Stall (out_valid=1, out_ready=0): Mout, out_ch, and out_valid hold; cur_ch and the scan counter continue to advance.
REQ-025 Latency: data presented at edge t appears on Mout after edge t+1, using the cur_ch value in effect during cycle t.
REQ-026 In manual mode, addr >= N (N not a power of two) selects no channel: no capture occurs, and cur_ch wraps to 0 in scan mode.
REQ-027 Simultaneous out_ready=1 and a new capture: the old sample is consumed and the new sample is loaded in the same edge, with out_valid staying 1.
REQ-028 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-029 When rst=1 at an edge: Mout=0, out_valid=0, out_ch=0, cur_ch=0, counter=0, and the FSM enters MANUAL.
REQ-030 Reset mid-operation discards any pending sample, regardless of out_ready.
REQ-031 The first capture can occur at the second edge after rst deasserts (cur_ch loads first).

Structure
REQ-032 Shared package chan_mux_pkg holds the mode encodings (MODE_MANUAL=0, MODE_SCAN=1), the FSM state typedef, and the CW width function.
REQ-033 The dwell counter plus channel pointer is one sub-module, chan_scan_ctr, with parameters N and DWELL, inputs clk, rst, en, load, and load_val, and output ch.
REQ-034 The datapath (mux, output register, handshake) stays in chan_mux_scan.

Verification
REQ-035 W=2, N=4: rst 3 cycles, then mode=0, addr=2, in_bus ch2=2'b11, in_valid=4'b0100, out_ready=1 -> after the second edge Mout=2'b11, out_ch=2, out_valid=1.
REQ-036 mode=1, DWELL=4, all in_valid=1 -> cur_ch sequence 0,0,0,0,1,1,1,1,2,...,3,3,3,3,0 (wrap), and out_ch tracks cur_ch one cycle later.
REQ-037 Capture ch1=2'b01, then out_ready=0 for 5 cycles while ch1 changes to 2'b10 -> Mout holds 2'b01 with out_valid=1; when out_ready=1, the next edge loads 2'b10.
REQ-038 in_valid=0 for the selected channel with out_ready=1 -> out_valid falls to 0 on the next edge, and Mout holds its last value.
REQ-039 Assert rst during a stall with out_valid=1 -> next edge out_valid=0, Mout=0, cur_ch=0, and the FSM is in MANUAL even if mode=1.
REQ-040 N=3, mode=0, addr=3 -> out_valid never asserts; switching to mode=1 scans 0,1,2,0.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel multiplexer: mode encodings, FSM states
// and the channel-index width helper.
package chan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  function automatic int cw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_scan_ctr.sv
// Channel pointer with dwell counter: load forces a channel and clears the
// dwell count, en steps through channels holding each for DWELL cycles.
module chan_scan_ctr
  import chan_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [cw_f(N)-1:0]  load_val,
  output logic [cw_f(N)-1:0]  ch
);

  localparam int CW   = cw_f(N);
  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   ch_q, ch_d;

  // Next pointer/count; an out-of-range pointer wraps to 0 on its next advance.
  always_comb begin
    cnt_d = cnt_q;
    ch_d  = ch_q;
    if (load) begin
      cnt_d = '0;
      ch_d  = load_val;
    end else if (en) begin
      if (cnt_q == CNTW'(DWELL - 1)) begin
        cnt_d = '0;
        ch_d  = (ch_q >= CW'(N - 1)) ? '0 : ch_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        ch_d  = ch_q;
      end
    end else begin
      cnt_d = cnt_q;
      ch_d  = ch_q;
    end
  end

  // Pointer and dwell registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ch_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ch_q  <= ch_d;
    end
  end

  assign ch = ch_q;

endmodule

// File: rtl/chan_mux_scan.sv
// N-channel data multiplexer with manual or auto-scan channel selection and a
// single registered output slot with valid/ready handshake.
module chan_mux_scan
  import chan_mux_pkg::*;
#(
  parameter int W     = 2,
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [cw_f(N)-1:0]  addr,
  input  logic [N*W-1:0]      in_bus,
  input  logic [N-1:0]        in_valid,
  input  logic                out_ready,
  output logic [W-1:0]        Mout,
  output logic                out_valid,
  output logic [cw_f(N)-1:0]  out_ch,
  output logic [cw_f(N)-1:0]  cur_ch
);

  localparam int CW = cw_f(N);

  state_e          state_q, state_d;
  logic            armed_q, armed_d;
  logic [W-1:0]    mout_q, mout_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_ch_q, out_ch_d;

  logic            load_s;
  logic            en_s;
  logic [W-1:0]    sel_data_s;
  logic            sel_vld_s;
  logic            capture_s;

  chan_scan_ctr #(
    .N     (N),
    .DWELL (DWELL)
  ) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .en       (en_s),
    .load     (load_s),
    .load_val (addr),
    .ch       (cur_ch)
  );

  // Mode tracking; entering or staying in manual reloads the pointer from addr.
  always_comb begin
    case (mode)
      MODE_SCAN: state_d = ST_SCAN;
      default:   state_d = ST_MANUAL;
    endcase
    load_s = (state_q == ST_MANUAL) || (mode == MODE_MANUAL);
    en_s   = !load_s;
  end

  // AND-OR channel mux; a pointer >= N matches no channel.
  always_comb begin
    sel_data_s = '0;
    sel_vld_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      sel_data_s = sel_data_s | ({W{cur_ch == CW'(k)}} & in_bus[k*W +: W]);
      sel_vld_s  = sel_vld_s | ((cur_ch == CW'(k)) & in_valid[k]);
    end
  end

  // Output slot: load when free, drain on ready, otherwise hold.
  always_comb begin
    armed_d     = 1'b1;
    capture_s   = (!out_valid_q || out_ready) && armed_q && sel_vld_s;
    mout_d      = mout_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (capture_s) begin
      mout_d      = sel_data_s;
      out_ch_d    = cur_ch;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MANUAL;
      armed_q     <= 1'b0;
      mout_q      <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      mout_q      <= mout_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign Mout      = mout_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Directed bench for chan_mux_scan: a behavioural model pushes expected outputs
// per cycle into a scoreboard, plus fixed-value checks of the key scenarios.
module tb_chan_mux_scan;

  logic       clk = 1'b0;
  logic       rst, mode, out_ready;
  logic [1:0] addr;
  logic [7:0] in_bus;
  logic [3:0] in_valid;
  logic [1:0] mout;
  logic       out_valid;
  logic [1:0] out_ch, cur_ch;

  logic       rst3, mode3, out_ready3;
  logic [1:0] addr3;
  logic [5:0] in_bus3;
  logic [2:0] in_valid3;
  logic [1:0] mout3;
  logic       out_valid3;
  logic [1:0] out_ch3, cur_ch3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int mout;
    int ov;
    int och;
    int cur;
  } exp_t;
  exp_t sb_q[$];

  int m_mout, m_ov, m_och, m_cur, m_cnt;
  bit m_scan, m_armed;

  always #5 clk = ~clk;

  chan_mux_scan #(.W(2), .N(4), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .addr(addr), .in_bus(in_bus),
    .in_valid(in_valid), .out_ready(out_ready), .Mout(mout),
    .out_valid(out_valid), .out_ch(out_ch), .cur_ch(cur_ch)
  );

  chan_mux_scan #(.W(2), .N(3), .DWELL(1)) dut3 (
    .clk(clk), .rst(rst3), .mode(mode3), .addr(addr3), .in_bus(in_bus3),
    .in_valid(in_valid3), .out_ready(out_ready3), .Mout(mout3),
    .out_valid(out_valid3), .out_ch(out_ch3), .cur_ch(cur_ch3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural next-state of the N=4 instance, computed from current inputs.
  task automatic model_advance();
    bit free;
    if (rst) begin
      m_mout = 0; m_ov = 0; m_och = 0; m_cur = 0; m_cnt = 0;
      m_scan = 1'b0; m_armed = 1'b0;
    end else begin
      free = (m_ov == 0) || out_ready;
      if (free && m_armed && m_cur < 4 && in_valid[m_cur]) begin
        m_mout = int'(in_bus[m_cur*2 +: 2]);
        m_och  = m_cur;
        m_ov   = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (!m_scan || !mode) begin
        m_cur = int'(addr);
        m_cnt = 0;
      end else if (m_cnt == 3) begin
        m_cnt = 0;
        m_cur = (m_cur >= 3) ? 0 : m_cur + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_scan  = mode;
      m_armed = 1'b1;
    end
  endtask

  task automatic step();
    exp_t e;
    model_advance();
    e.mout = m_mout; e.ov = m_ov; e.och = m_och; e.cur = m_cur;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_mout", 32'(mout), 32'(e.mout));
      chk("sb_out_valid", 32'(out_valid), 32'(e.ov));
      chk("sb_out_ch", 32'(out_ch), 32'(e.och));
      chk("sb_cur_ch", 32'(cur_ch), 32'(e.cur));
    end
  endtask

  initial begin
    logic [1:0] scan3 [4];
    int prev_cur;
    int exp_cur;
    scan3 = '{2'd0, 2'd1, 2'd2, 2'd0};

    rst = 1'b1; mode = 1'b0; addr = 2'd0; in_bus = 8'd0; in_valid = 4'd0; out_ready = 1'b0;
    rst3 = 1'b1; mode3 = 1'b0; addr3 = 2'd0; in_bus3 = 6'd0; in_valid3 = 3'd0; out_ready3 = 1'b0;
    #2;
    repeat (3) step();
    chk("rst_mout", 32'(mout), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_cur_ch", 32'(cur_ch), 32'd0);

    // N=3: out-of-range manual address never captures, then scan wraps
    rst3 = 1'b0; addr3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1; in_bus3 = 6'b10_01_11;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("n3_manual_no_valid", 32'(out_valid3), 32'd0);
    end
    mode3 = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("n3_scan_seq", 32'(cur_ch3), 32'(scan3[i]));
    end

    // Manual capture of channel 2, second edge after reset release
    rst = 1'b0; mode = 1'b0; addr = 2'd2; in_bus = 8'b00_11_00_00; in_valid = 4'b0100; out_ready = 1'b1;
    step();
    chk("man_first_edge_ov", 32'(out_valid), 32'd0);
    chk("man_first_edge_cur", 32'(cur_ch), 32'd2);
    step();
    chk("man_cap_mout", 32'(mout), 32'd3);
    chk("man_cap_och", 32'(out_ch), 32'd2);
    chk("man_cap_ov", 32'(out_valid), 32'd1);

    // Selected channel invalid with ready: slot drains, data holds
    in_valid = 4'b0000;
    step();
    chk("drain_ov", 32'(out_valid), 32'd0);
    chk("drain_mout_hold", 32'(mout), 32'd3);

    // Scan sequence with dwell 4 and wrap
    rst = 1'b1;
    step();
    rst = 1'b0; mode = 1'b1; addr = 2'd0; in_valid = 4'b1111;
    prev_cur = 0;
    for (int i = 1; i <= 17; i++) begin
      in_bus = 8'($urandom);
      step();
      exp_cur = ((i - 1) / 4) % 4;
      chk("scan_cur_seq", 32'(cur_ch), 32'(exp_cur));
      if (i >= 2) chk("scan_out_ch_lag", 32'(out_ch), 32'(prev_cur));
      prev_cur = exp_cur;
    end

    // Stall holds captured sample while input changes
    mode = 1'b0; addr = 2'd1; in_bus = 8'b00_00_01_00; out_ready = 1'b1;
    step();
    step();
    chk("stall_cap_mout", 32'(mout), 32'd1);
    chk("stall_cap_och", 32'(out_ch), 32'd1);
    out_ready = 1'b0; in_bus = 8'b00_00_10_00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold_mout", 32'(mout), 32'd1);
      chk("stall_hold_ov", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("stall_release_mout", 32'(mout), 32'd2);
    chk("stall_release_ov", 32'(out_valid), 32'd1);

    // Reset during a stall with mode=1
    out_ready = 1'b0; mode = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("rst_stall_ov", 32'(out_valid), 32'd0);
    chk("rst_stall_mout", 32'(mout), 32'd0);
    chk("rst_stall_cur", 32'(cur_ch), 32'd0);
    rst = 1'b0; addr = 2'd3;
    step();
    chk("rst_enters_manual", 32'(cur_ch), 32'd3);

    // Randomised traffic checked by the scoreboard
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      rst       = ($urandom_range(0, 39) == 0);
      addr      = 2'($urandom);
      in_bus    = 8'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
